// File: rtl/fp_square_seq_if.sv
// Operand/result handshake bundle for the sequential FP squarer.
// The master drives operands and consumes results; the slave is the squarer.
interface fp_square_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] A;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            overflow;
  logic            underflow;
  logic            exception;

  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, exception
  );

  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, result, overflow, underflow, exception
  );
endinterface

// File: rtl/fp_square_seq.sv
// Multi-cycle IEEE-754 single-precision squarer: radix-2 shift-add mantissa
// multiply (one product bit per cycle), RNE rounding, flush-to-zero.
module fp_square_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  fp_square_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t          state;
  logic [4:0]      cnt;
  logic [7:0]      exp_q;
  logic [23:0]     mcand;
  logic [23:0]     mplier;
  logic [47:0]     prod;
  logic [XLEN-1:0] result_q;
  logic            ovf_q, unf_q, exc_q;

  logic [7:0]      a_exp;
  logic [22:0]     a_frac;
  logic            accept;
  logic            unused_sign;

  assign a_exp       = bus.A[30:23];
  assign a_frac      = bus.A[22:0];
  // The square is always non-negative, so the operand sign never matters.
  assign unused_sign = bus.A[31];
  assign accept      = bus.in_valid && (state == IDLE);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.exception = exc_q;

  // Partial-product step: add the multiplicand into the upper half, then shift right.
  logic [24:0] step_sum;
  assign step_sum = {1'b0, prod[47:24]} + (mplier[0] ? {1'b0, mcand} : 25'd0);

  logic               n;
  logic [22:0]        frac;
  logic               guard, sticky, round_up;
  logic [23:0]        frac_rnd;
  logic signed [9:0]  er;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    n      = prod[47];
    frac   = prod[45:23];
    guard  = prod[22];
    sticky = |prod[21:0];
    if (n) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end
    round_up = guard && (sticky || frac[0]);
    frac_rnd = {1'b0, frac} + {23'd0, round_up};
    er       = $signed({1'b0, exp_q, 1'b0} - 10'd127 + {9'd0, n} + {9'd0, frac_rnd[23]});
  end

  // Control state, result and flags: these are architecturally visible after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (a_exp == 8'hFF) begin
              state    <= DONE;
              result_q <= (a_frac != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
              ovf_q    <= 1'b0;
              unf_q    <= 1'b0;
              exc_q    <= 1'b1;
            end else if (a_exp == 8'h00) begin
              state    <= DONE;
              result_q <= '0;
              ovf_q    <= 1'b0;
              unf_q    <= 1'b0;
              exc_q    <= 1'b0;
            end else begin
              state <= MUL;
              cnt   <= '0;
            end
          end
        end
        MUL: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd23) state <= NORM;
        end
        NORM: begin
          state <= DONE;
          exc_q <= 1'b0;
          if (er >= 10'sd255) begin
            result_q <= 32'h7F80_0000;
            ovf_q    <= 1'b1;
            unf_q    <= 1'b0;
          end else if (er <= 10'sd0) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b1;
          end else begin
            result_q <= {1'b0, er[7:0], frac_rnd[22:0]};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the multiplier datapath has no reset; it is fully reloaded on every accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      exp_q  <= a_exp;
      mcand  <= {1'b1, a_frac};
      mplier <= {1'b1, a_frac};
      prod   <= '0;
    end else if (state == MUL) begin
      prod   <= {step_sum, prod[23:1]};
      mplier <= {1'b0, mplier[23:1]};
    end
  end

endmodule
